nios_dct_packer: RTL and testbench

Trace-side producer for the Nios II OCI data/compression trace path. Packs 2-bit trace codes from the CPU trace interface into 30-bit words of up to 15 entries, and presents each word with its entry count as `dct_buffer` / `dct_count` to the OCI trace consumer and test-bench checker. Uses a valid/ready handshake with a single output holding register. Sits between the CPU trace-code source and the OCI trace FIFO.

---
 rtl/nios_dct_packer.sv | 101 ++++++++++
 tb/tb_nios_dct_packer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/nios_dct_packer.sv
// Packs 2-bit trace codes into 30-bit words of up to 15 entries and hands each
// word to the OCI trace consumer through a single valid/ready holding register.
module nios_dct_packer #(
   parameter int unsigned ENTRY_W = 2,
   parameter int unsigned DEPTH   = 15
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       trace_enable,
   input  logic                       dct_in_valid,
   input  logic [ENTRY_W-1:0]         dct_in,
   input  logic                       flush,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [ENTRY_W*DEPTH-1:0]   dct_buffer,
   output logic [3:0]                 dct_count,
   output logic                       overflow,
   input  logic                       overflow_clr
);

   localparam int unsigned BUF_W = ENTRY_W * DEPTH;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned SH_W  = 8;

   logic [BUF_W-1:0] acc, acc_n, appended, a_acc, load_buf;
   logic [CNT_W-1:0] acc_cnt, cnt_n, a_cnt, load_cnt;
   logic [SH_W-1:0]  shamt;
   logic             flush_pend, pend_n, te_q;
   logic             accept, hold_free, flush_req, pend, full, load, ovf_set;

   assign accept    = trace_enable & dct_in_valid;
   assign hold_free = ~out_valid | out_ready;
   assign flush_req = flush | (te_q & ~trace_enable);
   assign pend      = flush_pend | flush_req;
   assign full      = (acc_cnt == CNT_W'(DEPTH - 1));
   assign shamt     = SH_W'(acc_cnt) * SH_W'(ENTRY_W);
   assign appended  = acc | (BUF_W'(dct_in) << shamt);

   // Append first, then decide between completion, flush, or drop.
   always_comb begin
      a_acc    = accept ? appended : acc;
      a_cnt    = accept ? acc_cnt + CNT_W'(1) : acc_cnt;
      acc_n    = acc;
      cnt_n    = acc_cnt;
      pend_n   = pend;
      load     = 1'b0;
      load_buf = a_acc;
      load_cnt = a_cnt;
      ovf_set  = 1'b0;
      if (accept && full) begin
         if (hold_free) begin
            load     = 1'b1;
            load_buf = appended;
            load_cnt = CNT_W'(DEPTH);
            acc_n    = '0;
            cnt_n    = '0;
            pend_n   = 1'b0;
         end else begin
            ovf_set  = 1'b1;
         end
      end else begin
         acc_n = a_acc;
         cnt_n = a_cnt;
         if (pend && hold_free) begin
            pend_n = 1'b0;
            if (a_cnt != '0) begin
               load  = 1'b1;
               acc_n = '0;
               cnt_n = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc        <= '0;
         acc_cnt    <= '0;
         flush_pend <= 1'b0;
         te_q       <= 1'b0;
         out_valid  <= 1'b0;
         dct_buffer <= '0;
         dct_count  <= '0;
         overflow   <= 1'b0;
      end else begin
         acc        <= acc_n;
         acc_cnt    <= cnt_n;
         flush_pend <= pend_n;
         te_q       <= trace_enable;
         overflow   <= ovf_set | (overflow & ~overflow_clr);
         if (load) begin
            out_valid  <= 1'b1;
            dct_buffer <= load_buf;
            dct_count  <= load_cnt;
         end else if (out_ready) begin
            out_valid  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_nios_dct_packer.sv
// Directed self-checking bench for nios_dct_packer with hand-computed words.
module tb_nios_dct_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic        trace_enable, dct_in_valid, flush, out_ready, overflow_clr;
   logic [1:0]  dct_in;
   logic        out_valid, overflow;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   nios_dct_packer dut (
      .clk(clk), .reset(reset), .trace_enable(trace_enable),
      .dct_in_valid(dct_in_valid), .dct_in(dct_in), .flush(flush),
      .out_ready(out_ready), .out_valid(out_valid), .dct_buffer(dct_buffer),
      .dct_count(dct_count), .overflow(overflow), .overflow_clr(overflow_clr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [1:0] code);
      dct_in_valid = 1'b1;
      dct_in       = code;
      tick();
      dct_in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; trace_enable = 1'b0; dct_in_valid = 1'b0; dct_in = 2'd0;
      flush = 1'b0; out_ready = 1'b0; overflow_clr = 1'b0;
      #3;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_buf", 32'(dct_buffer), 32'd0);
      check("rst_cnt", 32'(dct_count), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      @(negedge clk);
      reset = 1'b0; trace_enable = 1'b1; out_ready = 1'b1;

      // Full word of 0,1,2,3,...
      for (int i = 0; i < 14; i++) push(2'(i % 4));
      check("full_not_yet", 32'(out_valid), 32'd0);
      push(2'd2);
      check("full_valid", 32'(out_valid), 32'd1);
      check("full_cnt", 32'(dct_count), 32'd15);
      check("full_buf", 32'(dct_buffer), 32'h24E4E4E4);
      tick();
      check("full_drop", 32'(out_valid), 32'd0);

      // Partial word via flush
      for (int i = 0; i < 5; i++) push(2'd3);
      flush = 1'b1; tick(); flush = 1'b0;
      check("fl_valid", 32'(out_valid), 32'd1);
      check("fl_cnt", 32'(dct_count), 32'd5);
      check("fl_buf", 32'(dct_buffer), 32'h3FF);
      tick();

      // Accept together with flush
      push(2'd1); push(2'd1);
      flush = 1'b1; push(2'd2); flush = 1'b0;
      check("af_cnt", 32'(dct_count), 32'd3);
      check("af_buf", 32'(dct_buffer), 32'h25);
      tick();

      // Backpressure: 30 codes, last dropped
      out_ready = 1'b0;
      for (int i = 0; i < 30; i++) begin
         push(2'd1);
         if (i == 14) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_cnt", 32'(dct_count), 32'd15);
            check("bp_buf", 32'(dct_buffer), 32'h15555555);
            check("bp_ovf0", 32'(overflow), 32'd0);
         end
      end
      check("bp_hold_buf", 32'(dct_buffer), 32'h15555555);
      check("bp_hold_cnt", 32'(dct_count), 32'd15);
      check("bp_ovf1", 32'(overflow), 32'd1);
      out_ready = 1'b1; tick();
      check("bp_xfer", 32'(out_valid), 32'd0);
      push(2'd2);
      check("bp2_cnt", 32'(dct_count), 32'd15);
      check("bp2_buf", 32'(dct_buffer), 32'h25555555);
      tick();
      check("bp2_done", 32'(out_valid), 32'd0);

      // Overflow clear semantics
      overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
      check("clr_alone", 32'(overflow), 32'd0);
      out_ready = 1'b0;
      for (int i = 0; i < 29; i++) push(2'd0);
      overflow_clr = 1'b1; push(2'd0);
      check("clr_and_drop", 32'(overflow), 32'd1);
      tick(); overflow_clr = 1'b0;
      check("clr_after", 32'(overflow), 32'd0);

      // Transfer and flush in the same cycle: back-to-back word
      out_ready = 1'b1; flush = 1'b1; tick(); flush = 1'b0;
      check("b2b_valid", 32'(out_valid), 32'd1);
      check("b2b_cnt", 32'(dct_count), 32'd14);
      tick();
      check("b2b_done", 32'(out_valid), 32'd0);

      // Auto-flush on trace_enable fall; input ignored while disabled
      for (int i = 0; i < 7; i++) push(2'd2);
      trace_enable = 1'b0; dct_in_valid = 1'b1; dct_in = 2'd3;
      tick();
      check("te_valid", 32'(out_valid), 32'd1);
      check("te_cnt", 32'(dct_count), 32'd7);
      check("te_buf", 32'(dct_buffer), 32'h2AAA);
      tick();
      dct_in_valid = 1'b0; trace_enable = 1'b1;
      flush = 1'b1; tick(); flush = 1'b0;
      check("te_ignored", 32'(out_valid), 32'd0);

      // Asynchronous reset mid-word
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) push(2'd1);
      flush = 1'b1; tick(); flush = 1'b0;
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 3; i++) push(2'd3);
      #2 reset = 1'b1;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_cnt", 32'(dct_count), 32'd0);
      check("arst_buf", 32'(dct_buffer), 32'd0);
      #1 reset = 1'b0;
      out_ready = 1'b1;
      push(2'd3);
      check("post_rst_idle", 32'(out_valid), 32'd0);
      flush = 1'b1; tick(); flush = 1'b0;
      check("post_rst_cnt", 32'(dct_count), 32'd1);
      check("post_rst_buf", 32'(dct_buffer), 32'h3);
      tick();
      check("post_rst_done", 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
